// File: rtl/ibus_resp_pkg.sv
// ibus_resp_pkg: shared types and constants for the instruction-bus memory
// responder.
//   - ibus_state_e : stage-2 fetch state
//   - line_entry_t : one-entry line buffer record (valid, tag, data)
//   - beat_addr()  : address of a 32-bit beat within a 64-bit fetch
package ibus_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } ibus_state_e;

    localparam int BEATS_PER_FETCH = 2;
    localparam int BEAT_BYTES      = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [63:0] data;
    } line_entry_t;

    // Address of beat 'idx' of the doubleword starting at 'base'.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [1:0] idx);
        beat_addr = base + (32'(idx) * 32'(BEAT_BYTES));
    endfunction

endpackage

// File: rtl/ibus_line_buffer.sv
// ibus_line_buffer: one-entry fetch line buffer.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears valid)
//   lookup_tag        8-byte aligned address being accepted
//   fill, fill_tag,   write a completed doubleword into the entry
//   fill_data
//   inv               clear the entry; wins over a coincident fill
//   hit, hit_data     lookup result; a fill happening this cycle is forwarded
//                     so a back-to-back refetch of the same line also hits
module ibus_line_buffer
    import ibus_resp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_tag,
    input  logic        fill,
    input  logic [31:0] fill_tag,
    input  logic [63:0] fill_data,
    input  logic        inv,
    output logic        hit,
    output logic [63:0] hit_data
);

    line_entry_t entry_r;

    // Entry register: invalidate has priority over fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_r <= '{valid: 1'b0, tag: 32'd0, data: 64'd0};
        end else if (inv) begin
            entry_r.valid <= 1'b0;
        end else if (fill) begin
            entry_r <= '{valid: 1'b1, tag: fill_tag, data: fill_data};
        end else begin
            entry_r <= entry_r;
        end
    end

    // Tag compare with forwarding of the fill in progress.
    always_comb begin
        hit      = 1'b0;
        hit_data = entry_r.data;
        if (inv) begin
            hit = 1'b0;
        end else if (fill && (fill_tag == lookup_tag)) begin
            hit      = 1'b1;
            hit_data = fill_data;
        end else if (entry_r.valid && (entry_r.tag == lookup_tag)) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

endmodule

// File: rtl/ibus_mem_responder.sv
// ibus_mem_responder: slave end of the 2-stage pipelined instruction-fetch
// bus, serving each 64-bit fetch as two in-order 32-bit memory beats.
// Responses still in flight for flushed fetches are counted and discarded.
// Optional feature macro: IBUS_LINE_BUFFER_EN (one-entry line buffer).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   ibus_read, ibus_address         stage-1 fetch request (address [2:0] ignored)
//   ibus_flush_1, ibus_flush_2      kill stage-1 / stage-2 request
//   ibus_stall, ibus_valid,         stage-2 status and fetched doubleword
//   ibus_rddata
//   ibus_inv                        invalidate line buffer (feature only)
//   mem_req, mem_addr, mem_gnt      beat request handshake
//   mem_rvalid, mem_rdata           in-order beat response
module ibus_mem_responder
    import ibus_resp_pkg::*;
#(
    parameter int DROP_CNT_W     = 3,
    parameter int RESET_PC_ALIGN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ibus_read,
    input  logic [31:0] ibus_address,
    input  logic        ibus_flush_1,
    input  logic        ibus_flush_2,
    output logic        ibus_stall,
    output logic        ibus_valid,
    output logic [63:0] ibus_rddata,
    input  logic        ibus_inv,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    if (RESET_PC_ALIGN != 8) begin : g_align_check
        $error("ibus_mem_responder: RESET_PC_ALIGN must be 8");
    end
    if (DROP_CNT_W < 2) begin : g_drop_w_check
        $error("ibus_mem_responder: DROP_CNT_W must be at least 2");
    end

    localparam int                    DW1      = DROP_CNT_W + 1;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_0   = {DROP_CNT_W{1'b0}};
    localparam logic [1:0]            ALL_BEATS = 2'(BEATS_PER_FETCH);

    ibus_state_e           state_r;
    ibus_state_e           state_nxt_s;
    logic [31:0]           base_r;
    logic [1:0]            issued_r;
    logic [1:0]            recv_r;
    logic [31:0]           beat0_r;
    logic [31:0]           beat1_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;
    logic [DROP_CNT_W-1:0] drop_nxt_s;
    logic [DW1-1:0]        drop_sum_s;
    logic                  busy_s;
    logic                  stall_s;
    logic                  req_s;
    logic                  hs_s;
    logic                  drop_beat_s;
    logic                  take_beat_s;
    logic                  accept_s;
    logic [1:0]            issued_nxt_s;
    logic [1:0]            recv_nxt_s;
    logic [1:0]            flush_inc_s;
    logic [31:0]           fetch_base_s;
    logic                  hit_s;
    logic [63:0]           hit_data_s;
    logic                  unused_s;

    assign unused_s = ^{ibus_address[2:0], ibus_inv};

`ifdef IBUS_LINE_BUFFER_EN
    ibus_line_buffer u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (fetch_base_s),
        .fill       (state_r == S_DONE),
        .fill_tag   (base_r),
        .fill_data  ({beat1_r, beat0_r}),
        .inv        (ibus_inv),
        .hit        (hit_s),
        .hit_data   (hit_data_s)
    );
`else
    assign hit_s      = 1'b0;
    assign hit_data_s = 64'd0;
`endif

    // Handshake decode, response routing and discard-counter arithmetic.
    always_comb begin
        busy_s       = (state_r == S_ISSUE) || (state_r == S_WAIT);
        stall_s      = busy_s && !ibus_flush_2;
        req_s        = (state_r == S_ISSUE) && (drop_cnt_r != DROP_MAX);
        hs_s         = req_s && mem_gnt;
        drop_beat_s  = mem_rvalid && (drop_cnt_r != DROP_0);
        take_beat_s  = mem_rvalid && (drop_cnt_r == DROP_0) && busy_s && (recv_r < ALL_BEATS);
        issued_nxt_s = issued_r + {1'b0, hs_s};
        recv_nxt_s   = recv_r + {1'b0, take_beat_s};
        accept_s     = ibus_read && !stall_s && !ibus_flush_1 && !ibus_flush_2;
        fetch_base_s = {ibus_address[31:3], 3'b000};
        // A killed fetch leaves (issued - received) responses to swallow,
        // including a grant or a response landing in the flush cycle itself.
        if (busy_s && ibus_flush_2) begin
            flush_inc_s = issued_nxt_s - recv_nxt_s;
        end else begin
            flush_inc_s = 2'd0;
        end
        drop_sum_s = DW1'(drop_cnt_r) + DW1'(flush_inc_s) - DW1'(drop_beat_s);
        // Clamp instead of wrapping so the counter can never read as empty.
        if (drop_sum_s > DW1'(DROP_MAX)) begin
            drop_nxt_s = DROP_MAX;
        end else begin
            drop_nxt_s = drop_sum_s[DROP_CNT_W-1:0];
        end
    end

    // Next-state logic: internal progress while stalled, else stage-1 accept.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_ISSUE: begin
                if (issued_nxt_s == ALL_BEATS) begin
                    state_nxt_s = (recv_nxt_s == ALL_BEATS) ? S_DONE : S_WAIT;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (recv_nxt_s == ALL_BEATS) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            default: begin
                state_nxt_s = state_r;
            end
        endcase
        if (!stall_s) begin
            if (accept_s) begin
                state_nxt_s = hit_s ? S_DONE : S_ISSUE;
            end else begin
                state_nxt_s = S_IDLE;
            end
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Discarded-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= DROP_0;
        end else begin
            drop_cnt_r <= drop_nxt_s;
        end
    end

    // Stage-2 fetch context: base address, beat counters and beat data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r   <= 32'd0;
            issued_r <= 2'd0;
            recv_r   <= 2'd0;
            beat0_r  <= 32'd0;
            beat1_r  <= 32'd0;
        end else if (accept_s) begin
            base_r   <= fetch_base_s;
            issued_r <= 2'd0;
            recv_r   <= 2'd0;
            if (hit_s) begin
                beat0_r <= hit_data_s[31:0];
                beat1_r <= hit_data_s[63:32];
            end
        end else if (!stall_s) begin
            issued_r <= 2'd0;
            recv_r   <= 2'd0;
        end else begin
            issued_r <= issued_nxt_s;
            recv_r   <= recv_nxt_s;
            if (take_beat_s) begin
                if (recv_r == 2'd0) begin
                    beat0_r <= mem_rdata;
                end else begin
                    beat1_r <= mem_rdata;
                end
            end
        end
    end

    assign ibus_stall  = stall_s;
    assign ibus_valid  = (state_r == S_DONE);
    assign ibus_rddata = {beat1_r, beat0_r};
    assign mem_req     = req_s;
    assign mem_addr    = beat_addr(base_r, issued_r);

endmodule

// File: tb/tb_ibus_mem_responder.sv
// Self-checking bench for ibus_mem_responder: directed steps from the test
// plan followed by randomized fetch/flush/grant/latency traffic. A
// transaction-level model tracks the live fetch and every outstanding memory
// response (tagged with the fetch that requested it) and predicts the bus
// outputs every cycle.
module tb_ibus_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ibus_read;
    logic [31:0] ibus_address;
    logic        ibus_flush_1;
    logic        ibus_flush_2;
    logic        ibus_stall;
    logic        ibus_valid;
    logic [63:0] ibus_rddata;
    logic        ibus_inv;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    ibus_mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ibus_read    (ibus_read),
        .ibus_address (ibus_address),
        .ibus_flush_1 (ibus_flush_1),
        .ibus_flush_2 (ibus_flush_2),
        .ibus_stall   (ibus_stall),
        .ibus_valid   (ibus_valid),
        .ibus_rddata  (ibus_rddata),
        .ibus_inv     (ibus_inv),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        int          owner;
        int          ready;
    } resp_t;

    resp_t       rq[$];
    logic [31:0] mem_init [logic [31:0]];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          gnt_mode = 0;   // 0: always grant, 1: random, 2: never
    int          lat = 1;
    bit          resp_hold = 1'b0;

    // reference model: 0 idle, 1 fetching, 2 delivering
    int          m_phase = 0;
    int          m_issued = 0;
    int          m_got = 0;
    int          m_id = 0;
    logic [31:0] m_base = 32'd0;
    bit          lb_valid = 1'b0;
    logic [31:0] lb_tag = 32'd0;

    bit          s_stall, s_valid, s_req;
    logic [63:0] s_rddata;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_init.exists(a)) return mem_init[a];
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (rq[i]) if (rq[i].owner != m_id) n++;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus cycle: drive memory, check outputs against the model, advance.
    task automatic cycle();
        bit          rv, exp_stall, exp_valid, exp_req, hit;
        int          stale, nxt;
        logic [31:0] nb;
        resp_t       r;
        rv = 1'b0;
        if (!resp_hold && rq.size() > 0) begin
            if (rq[0].ready <= cyc) rv = 1'b1;
        end
        mem_rvalid = rv;
        mem_rdata  = 32'd0;
        if (rv) mem_rdata = mem_rd(rq[0].addr);
        if (gnt_mode == 0)      mem_gnt = 1'b1;
        else if (gnt_mode == 2) mem_gnt = 1'b0;
        else                    mem_gnt = ($urandom_range(0, 99) < 70);
        #1;
        stale     = stale_cnt();
        exp_stall = (m_phase == 1) && !ibus_flush_2;
        exp_valid = (m_phase == 2);
        exp_req   = (m_phase == 1) && (m_issued < 2) && (stale != 7);
        chk("stall", ibus_stall, exp_stall);
        chk("valid", ibus_valid, exp_valid);
        if (exp_valid) chk("rddata", ibus_rddata, {mem_rd(m_base + 32'd4), mem_rd(m_base)});
        chk("mem_req", mem_req, exp_req);
        if (exp_req) chk("mem_addr", mem_addr, m_base + 32'(4 * m_issued));
        s_stall = ibus_stall; s_valid = ibus_valid; s_rddata = ibus_rddata;
        s_req = mem_req; s_addr = mem_addr;
        // memory side follows what the design actually asked for
        if (mem_req && mem_gnt) rq.push_back('{mem_addr, m_id, cyc + lat});
        if (exp_req && mem_gnt) m_issued++;
        if (rv) begin
            r = rq.pop_front();
            if (r.owner == m_id && m_phase == 1 && m_got < 2) m_got++;
        end
        nb = {ibus_address[31:3], 3'b000};
`ifdef IBUS_LINE_BUFFER_EN
        hit = !ibus_inv && ((lb_valid && lb_tag == nb) || (m_phase == 2 && m_base == nb));
        if (ibus_inv) lb_valid = 1'b0;
        else if (m_phase == 2) begin lb_valid = 1'b1; lb_tag = m_base; end
`else
        hit = 1'b0;
`endif
        nxt = m_phase;
        if (m_phase == 1 && m_issued == 2 && m_got == 2) nxt = 2;
        if (!exp_stall) begin
            if (ibus_read && !ibus_flush_1 && !ibus_flush_2) begin
                m_id++;
                m_base = nb; m_issued = 0; m_got = 0;
                nxt = hit ? 2 : 1;
            end else begin
                if (m_phase == 1) m_id++;   // killed fetch: its responses go stale
                nxt = 0;
            end
        end
        m_phase = nxt;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            if (s_valid) seen = 1'b1;
        end
        chk({tag, "_valid_timeout"}, seen, 1'b1);
    endtask

    task automatic idle();
        ibus_read = 1'b0; ibus_flush_1 = 1'b0; ibus_flush_2 = 1'b0; ibus_inv = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; idle(); ibus_address = 32'd0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        mem_init[32'h1FC00000] = 32'h11111111; mem_init[32'h1FC00004] = 32'h22222222;
        mem_init[32'h1FC00008] = 32'h33333333; mem_init[32'h1FC0000C] = 32'h44444444;
        mem_init[32'h00000200] = 32'h0000DEAD;
        mem_init[32'h00000080] = 32'h0000000A; mem_init[32'h00000084] = 32'h0000000B;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", ibus_stall, 1'b0);
        chk("rst_valid", ibus_valid, 1'b0);
        chk("rst_rddata", ibus_rddata, 64'd0);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single fetch, zero-wait memory: stall C1-C3, valid in C4
        ibus_read = 1'b1; ibus_address = 32'h1FC00004;
        cycle();
        idle();
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk("t1_stall", s_stall, (k <= 3));
            chk("t1_valid", s_valid, (k == 4));
            if (k == 1) chk("t1_addr0", s_addr, 32'h1FC00000);
            if (k == 2) chk("t1_addr1", s_addr, 32'h1FC00004);
        end
        chk("t1_rddata", s_rddata, 64'h22222222_11111111);
        cycle();

        // wait states on beat1: request held stable
        ibus_read = 1'b1; ibus_address = 32'h1FC00008;
        cycle();
        idle();
        cycle();
        gnt_mode = 2;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t2_req_hold", s_req, 1'b1);
            chk("t2_addr_hold", s_addr, 32'h1FC0000C);
            chk("t2_stall_hold", s_stall, 1'b1);
        end
        gnt_mode = 0;
        wait_valid("t2", 10);
        chk("t2_rddata", s_rddata, 64'h44444444_33333333);
        cycle();

        // flush_2 after beat0 granted, before its response returns
        lat = 3;
        ibus_read = 1'b1; ibus_address = 32'h00000200;
        cycle();
        idle();
        cycle();
        gnt_mode = 2; ibus_flush_1 = 1'b1; ibus_flush_2 = 1'b1;
        cycle();
        chk("t3_flush_stall", s_stall, 1'b0);
        idle();
        lat = 1; gnt_mode = 0;
        ibus_read = 1'b1; ibus_address = 32'h00000080;
        cycle();
        idle();
        wait_valid("t3", 15);
        chk("t3_rddata", s_rddata, 64'h0000000B_0000000A);
        cycle();

        // flush_1 kills the stage-1 request
        ibus_read = 1'b1; ibus_flush_1 = 1'b1; ibus_address = 32'h00000300;
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t4_no_req", s_req, 1'b0);
            chk("t4_no_valid", s_valid, 1'b0);
        end

        // drop counter saturation
        resp_hold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ibus_read = 1'b1; ibus_address = 32'h00000400 + 32'(16 * i);
            cycle();
            idle(); gnt_mode = 0;
            cycle();
            gnt_mode = 2; ibus_flush_1 = 1'b1; ibus_flush_2 = 1'b1;
            cycle();
            idle(); gnt_mode = 0;
        end
        ibus_read = 1'b1; ibus_address = 32'h00000500;
        cycle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_sat_no_req", s_req, 1'b0);
            chk("t5_sat_stall", s_stall, 1'b1);
        end
        resp_hold = 1'b0;
        cycle();
        chk("t5_still_sat", s_req, 1'b0);
        cycle();
        chk("t5_req_resumes", s_req, 1'b1);
        wait_valid("t5", 40);
        chk("t5_rddata", s_rddata, {mem_rd(32'h00000504), mem_rd(32'h00000500)});
        cycle();

`ifdef IBUS_LINE_BUFFER_EN
        // line buffer hit, then invalidate forces a refetch
        ibus_read = 1'b1; ibus_address = 32'h00000100;
        cycle();
        idle();
        wait_valid("t6a", 10);
        cycle();
        ibus_read = 1'b1; ibus_address = 32'h00000100;
        cycle();
        idle();
        cycle();
        chk("t6_hit_valid", s_valid, 1'b1);
        chk("t6_hit_no_req", s_req, 1'b0);
        ibus_inv = 1'b1;
        cycle();
        idle();
        ibus_read = 1'b1; ibus_address = 32'h00000100;
        cycle();
        idle();
        cycle();
        chk("t6_refetch_req", s_req, 1'b1);
        wait_valid("t6c", 10);
        cycle();
`endif

        // randomized traffic
        gnt_mode = 1;
        for (int i = 0; i < 400; i++) begin
            ibus_read    = ($urandom_range(0, 99) < 70);
            ibus_address = 32'h00001000 + 32'(8 * $urandom_range(0, 7)) + 32'($urandom_range(0, 7));
            ibus_flush_1 = ($urandom_range(0, 99) < 8);
            ibus_flush_2 = 1'b0;
            if ($urandom_range(0, 99) < 8 && stale_cnt() + 2 <= 7) begin
                ibus_flush_2 = 1'b1; ibus_flush_1 = 1'b1;
            end
            ibus_inv = ($urandom_range(0, 99) < 5);
            lat = $urandom_range(1, 3);
            cycle();
        end

        // drain
        idle(); gnt_mode = 0; lat = 1;
        repeat (30) cycle();
        chk("drain_queue_empty", 64'(rq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
